// File: rtl/instr_encoder_loader_if.sv
// Bundle-in / imem-write-out bus of the instruction encoder-loader.
// The master side (host or program feed) drives field bundles and observes the
// imem write port. The slave side (encoder) accepts bundles and drives the writes.
interface instr_encoder_loader_if;

  // Field bundle handshake
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  op_class;
  logic [1:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;

  // Instruction memory write port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid,
    output in_last,
    output op_class,
    output alu_op,
    output rd,
    output rs1,
    output rs2,
    output imm,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  op_class,
    input  alu_op,
    input  rd,
    input  rs1,
    input  rs2,
    input  imm,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder-loader: turns (class, alu_op, rd, rs1, rs2, imm) bundles into
// RV32I-subset words (R, I-ALU, lw, sw, beq) and writes them to consecutive imem
// words, one write per accepted bundle, one cycle after acceptance.
// Optional build macro IMM_RANGE_CHECK_EN: flags immediates that do not fit their
// format (I/LOAD/STORE with imm[12]!=imm[11], BRANCH with imm[0]=1) as illegal.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       word_count,
  output logic                  err_illegal,
  output logic                  err_full
);

  localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_AND = 2'd3;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0]  F3_WORD = 3'b010;
  localparam logic [2:0]  F3_BEQ  = 3'b000;
  localparam logic [6:0]  F7_SUB  = 7'b0100000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] count_inc;
  logic            err_illegal_q, err_illegal_d;
  logic            err_full_q, err_full_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            accept;
  logic            launch;
  logic [31:0]     count_ext;
  logic [31:0]     slot_addr;

  logic [31:0]     enc_word;
  logic            enc_illegal;
  logic [2:0]      alu_f3;
  logic [6:0]      r_f7;
  logic            imm_bad;

  // Handshake and control strobes
  assign bus.in_ready = (state_q == StRun) && (count_q != CAPACITY);
  assign accept       = bus.in_valid && bus.in_ready;
  // start is only honoured outside RUN
  assign launch       = start && (state_q != StRun);
  assign count_inc    = count_q + COUNT_ONE;

  // Byte address of the slot the next accepted bundle will occupy
  always_comb begin
    count_ext             = '0;
    count_ext[ADDR_W:0]   = count_q;
    slot_addr             = BASE_ADDR + (count_ext << 2);
  end

  // Encode the presented bundle; illegal bundles collapse to a NOP
  always_comb begin
    enc_word    = NOP;
    enc_illegal = 1'b0;
    alu_f3      = 3'b000;
    r_f7        = 7'b0000000;
    imm_bad     = 1'b0;

    unique case (bus.alu_op)
      ALU_ADD: alu_f3 = 3'b000;
      ALU_SUB: alu_f3 = 3'b000;
      ALU_OR:  alu_f3 = 3'b110;
      ALU_AND: alu_f3 = 3'b111;
      default: alu_f3 = 3'b000;
    endcase

`ifdef IMM_RANGE_CHECK_EN
    if ((bus.op_class == CLS_I) || (bus.op_class == CLS_LOAD) ||
        (bus.op_class == CLS_STORE)) begin
      imm_bad = (bus.imm[12] != bus.imm[11]);
    end else if (bus.op_class == CLS_BRANCH) begin
      imm_bad = bus.imm[0];
    end
`else
    imm_bad = 1'b0;
`endif

    case (bus.op_class)
      CLS_R: begin
        if (bus.alu_op == ALU_SUB) r_f7 = F7_SUB;
        enc_word = {r_f7, bus.rs2, bus.rs1, alu_f3, bus.rd, OPC_R};
      end
      CLS_I: begin
        // There is no subi; an I-ALU sub cannot be encoded
        if (bus.alu_op == ALU_SUB) begin
          enc_illegal = 1'b1;
        end else begin
          enc_word = {bus.imm[11:0], bus.rs1, alu_f3, bus.rd, OPC_I};
        end
      end
      CLS_LOAD: begin
        enc_word = {bus.imm[11:0], bus.rs1, F3_WORD, bus.rd, OPC_LOAD};
      end
      CLS_STORE: begin
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, F3_WORD, bus.imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, F3_BEQ,
                    bus.imm[4:1], bus.imm[11], OPC_BRANCH};
      end
      default: begin
        enc_illegal = 1'b1;
      end
    endcase

    if (imm_bad) enc_illegal = 1'b1;
    if (enc_illegal) enc_word = NOP;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave RUN on the last bundle or when the final slot is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (accept && (bus.in_last || (count_inc == CAPACITY))) state_d = StDone;
      end
      StDone: begin
        if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, sticky errors and the registered imem write
  always_comb begin
    count_d       = count_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    if (launch) begin
      count_d       = '0;
      err_illegal_d = 1'b0;
      err_full_d    = 1'b0;
    end else if (accept) begin
      count_d     = count_inc;
      mem_we_d    = 1'b1;
      mem_addr_d  = slot_addr;
      mem_wdata_d = enc_word;
      if (enc_illegal) err_illegal_d = 1'b1;
      if ((count_inc == CAPACITY) && !bus.in_last) err_full_d = 1'b1;
    end
  end

  // Datapath registers; reset also drops a write still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign word_count  = count_q;
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a full-size loader (ADDR_W=8, base 0) and a
// four-word loader (ADDR_W=2, base 0x100). Stimulus queues expected imem writes;
// per-instance monitors pop and compare whenever mem_we is seen.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE_B = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_a, start_b;
  logic        valid_a, valid_b;
  logic        last;
  logic [2:0]  cls;
  logic [1:0]  aop;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [12:0] f_imm;

  logic        busy_a, done_a, erri_a, errf_a;
  logic [8:0]  wc_a;
  logic        busy_b, done_b, erri_b, errf_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;
  int idx_a  = 0;
  int idx_b  = 0;
  exp_t qa[$];
  exp_t qb[$];

  instr_encoder_loader_if a_if ();
  instr_encoder_loader_if b_if ();

  assign a_if.in_valid = valid_a;
  assign a_if.in_last  = last;
  assign a_if.op_class = cls;
  assign a_if.alu_op   = aop;
  assign a_if.rd       = f_rd;
  assign a_if.rs1      = f_rs1;
  assign a_if.rs2      = f_rs2;
  assign a_if.imm      = f_imm;

  assign b_if.in_valid = valid_b;
  assign b_if.in_last  = last;
  assign b_if.op_class = cls;
  assign b_if.alu_op   = aop;
  assign b_if.rd       = f_rd;
  assign b_if.rs1      = f_rs1;
  assign b_if.rs2      = f_rs2;
  assign b_if.imm      = f_imm;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .bus        (a_if),
    .busy       (busy_a),
    .done       (done_a),
    .word_count (wc_a),
    .err_illegal(erri_a),
    .err_full   (errf_a)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(BASE_B)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .bus        (b_if),
    .busy       (busy_b),
    .done       (done_b),
    .word_count (wc_b),
    .err_illegal(erri_b),
    .err_full   (errf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (a_if.mem_we === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write actual addr=%h data=%h required no write",
                 a_if.mem_addr, a_if.mem_wdata);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_mem_addr", a_if.mem_addr, e.addr);
        chk("a_mem_wdata", a_if.mem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.mem_we === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write actual addr=%h data=%h required no write",
                 b_if.mem_addr, b_if.mem_wdata);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_mem_addr", b_if.mem_addr, e.addr);
        chk("b_mem_wdata", b_if.mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) begin
      start_b = 1'b1;
      idx_b   = 0;
    end else begin
      start_a = 1'b1;
      idx_a   = 0;
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Present one bundle, wait (bounded) for acceptance and queue its expected write
  task automatic send(input bit to_b, input logic [2:0] c, input logic [1:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [12:0] im, input bit lst, input logic [31:0] exp_word);
    int   waited;
    exp_t e;
    waited = 0;
    cls = c; aop = op; f_rd = d; f_rs1 = s1; f_rs2 = s2; f_imm = im; last = lst;
    if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
    while (((to_b ? b_if.in_ready : a_if.in_ready) !== 1'b1) && (waited < 20)) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required 1");
      valid_a = 1'b0;
      valid_b = 1'b0;
      return;
    end
    e.data = exp_word;
    if (to_b) begin
      e.addr = BASE_B + 32'(4 * idx_b);
      idx_b++;
      qb.push_back(e);
    end else begin
      e.addr = 32'(4 * idx_a);
      idx_a++;
      qa.push_back(e);
    end
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    last    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] range_exp;
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    last = 1'b0; cls = '0; aop = '0; f_rd = '0; f_rs1 = '0; f_rs2 = '0; f_imm = '0;
    #1 reset = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_word_count", 32'(wc_a), 32'd0);
    chk("rst_err_illegal", 32'(erri_a), 32'd0);
    chk("rst_err_full", 32'(errf_a), 32'd0);
    chk("rst_mem_we", 32'(a_if.mem_we), 32'd0);
    chk("rst_mem_addr", a_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", a_if.mem_wdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 32'(a_if.in_ready), 32'd0);

    // Program on the full-size loader
    pulse_start(1'b0);
    chk("run_busy", 32'(busy_a), 32'd1);
    chk("run_in_ready", 32'(a_if.in_ready), 32'd1);
    send(1'b0, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
    send(1'b0, 3'd0, 2'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0, 32'h407302B3);
    send(1'b0, 3'd2, 2'd0, 5'd4, 5'd2, 5'd0, 13'h1FFC, 1'b0, 32'hFFC12203);
    send(1'b0, 3'd3, 2'd0, 5'd0, 5'd1, 5'd5, 13'd8, 1'b0, 32'h0050A423);
    // The store was accepted on the edge right after the load's write
    chk("b2b_store_we", 32'(a_if.mem_we), 32'd1);
    chk("b2b_word_count", 32'(wc_a), 32'd4);
    send(1'b0, 3'd6, 2'd0, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, NOP);
    tick();
    chk("illegal_flag", 32'(erri_a), 32'd1);
    send(1'b0, 3'd1, 2'd2, 5'd1, 5'd2, 5'd0, 13'h07FF, 1'b0, 32'h7FF16093);
    send(1'b0, 3'd1, 2'd1, 5'd1, 5'd2, 5'd0, 13'd0, 1'b0, NOP);
`ifdef IMM_RANGE_CHECK_EN
    range_exp = NOP;
`else
    range_exp = 32'h00000163;
`endif
    send(1'b0, 3'd4, 2'd0, 5'd0, 5'd0, 5'd0, 13'd3, 1'b0, range_exp);
    send(1'b0, 3'd4, 2'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 32'hFE208CE3);
    tick();
    chk("a_done", 32'(done_a), 32'd1);
    chk("a_busy_after", 32'(busy_a), 32'd0);
    chk("a_word_count", 32'(wc_a), 32'd9);
    chk("a_err_full", 32'(errf_a), 32'd0);
    chk("a_done_in_ready", 32'(a_if.in_ready), 32'd0);

    // Restart from DONE clears count and sticky errors
    pulse_start(1'b0);
    chk("restart_word_count", 32'(wc_a), 32'd0);
    chk("restart_err_illegal", 32'(erri_a), 32'd0);
    send(1'b0, 3'd0, 2'd3, 5'd7, 5'd8, 5'd9, 13'd0, 1'b1, 32'h009473B3);
    tick();
    chk("restart_done", 32'(done_a), 32'd1);

    // Four-word loader: overflow without in_last
    pulse_start(1'b1);
    send(1'b1, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
    send(1'b1, 3'd0, 2'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0, 32'h407302B3);
    send(1'b1, 3'd2, 2'd0, 5'd4, 5'd2, 5'd0, 13'h1FFC, 1'b0, 32'hFFC12203);
    send(1'b1, 3'd3, 2'd0, 5'd0, 5'd1, 5'd5, 13'd8, 1'b0, 32'h0050A423);
    tick();
    chk("full_done", 32'(done_b), 32'd1);
    chk("full_err_full", 32'(errf_b), 32'd1);
    chk("full_word_count", 32'(wc_b), 32'd4);
    chk("full_in_ready", 32'(b_if.in_ready), 32'd0);
    // A fifth bundle is refused and produces no write
    cls = 3'd0; aop = 2'd0; f_rd = 5'd1; f_rs1 = 5'd1; f_rs2 = 5'd1; valid_b = 1'b1;
    repeat (3) tick();
    chk("fifth_in_ready", 32'(b_if.in_ready), 32'd0);
    chk("fifth_word_count", 32'(wc_b), 32'd4);
    valid_b = 1'b0;

    // in_last on the final-capacity bundle is not an overflow
    pulse_start(1'b1);
    chk("b_restart_err_full", 32'(errf_b), 32'd0);
    send(1'b1, 3'd0, 2'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h0020E1B3);
    send(1'b1, 3'd7, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, NOP);
    send(1'b1, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
    send(1'b1, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
    tick();
    chk("last_full_done", 32'(done_b), 32'd1);
    chk("last_full_err_full", 32'(errf_b), 32'd0);
    chk("last_full_err_illegal", 32'(erri_b), 32'd1);

    // Reset in the middle of a run
    pulse_start(1'b1);
    send(1'b1, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
    tick();
    chk("mid_busy_before", 32'(busy_b), 32'd1);
    reset = 1'b1;
    #2;
    chk("mid_rst_busy", 32'(busy_b), 32'd0);
    chk("mid_rst_done", 32'(done_b), 32'd0);
    chk("mid_rst_word_count", 32'(wc_b), 32'd0);
    chk("mid_rst_mem_we", 32'(b_if.mem_we), 32'd0);
    chk("mid_rst_mem_addr", b_if.mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", b_if.mem_wdata, 32'd0);
    chk("mid_rst_in_ready", 32'(b_if.in_ready), 32'd0);
    chk("mid_rst_errs", {30'd0, erri_b, errf_b}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
